// File: rtl/fetch_seq.sv
// fetch_seq: four-step instruction sequencer (FETCH -> DECODE -> EXEC -> UPDATE).
// Fetches one word per instruction from a request/acknowledge instruction memory,
// holds it in the instruction register, strobes the decoder once, waits one cycle
// for the decoder's registered controls, then computes and loads the next PC.
// A stall freezes everything except the capture of a memory word that arrives
// during FETCH; the move to DECODE is then deferred until the stall drops.
module fetch_seq (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        Beq,
  input  logic        Bne,
  input  logic        J,
  input  logic        Z,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  // Set when a word was captured in FETCH while stalled; lets the sequencer
  // leave FETCH once the stall drops even if the memory no longer acknowledges.
  logic        r_ir_held;

  logic        w_ld_ir;
  logic        w_ld_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic        w_br_taken;
  logic [31:0] w_pc_next;

  // State register; reset forces FETCH regardless of stall or any other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection plus the per-state strobes (request, decode strobe, loads).
  always_comb begin
    w_state_next = r_state;
    w_ld_ir      = 1'b0;
    w_ld_pc      = 1'b0;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    case (r_state)
      S_FETCH: begin
        // Request is gated by reset so it is low during any reset cycle and
        // rises in the first cycle after release.
        imem_req = rst;
        w_ld_ir  = imem_ack;
        if (!stall && (imem_ack || r_ir_held)) begin
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        instr_valid = rst & ~stall;
        if (!stall) begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          w_state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (!stall) begin
          w_ld_pc      = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Next-PC candidates; all adds wrap modulo 2^32 with no overflow indication.
  always_comb begin
    w_pc_plus4  = r_pc + 32'd4;
    w_br_off    = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
    w_br_target = w_pc_plus4 + w_br_off;
    w_j_target  = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
    // With both branch flavours asserted, either condition takes the branch.
    w_br_taken  = (Beq & Z) | (Bne & ~Z);
  end

  // Next-PC priority: register jump, then absolute jump, then branch, then sequential.
  // The register-jump target is used exactly as given (no alignment masking).
  always_comb begin
    if (jr) begin
      w_pc_next = jr_target;
    end else if (J) begin
      w_pc_next = w_j_target;
    end else if (w_br_taken) begin
      w_pc_next = w_br_target;
    end else begin
      w_pc_next = w_pc_plus4;
    end
  end

  // Datapath registers: IR captured on any acknowledge in FETCH (even when
  // stalled), PC loaded only on a non-stalled UPDATE; reset abandons all of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc      <= 32'h0000_0000;
      r_ir      <= 32'h0000_0000;
      r_ir_held <= 1'b0;
    end else begin
      if (w_ld_ir) begin
        r_ir <= imem_rdata;
      end
      if (r_state == S_FETCH) begin
        r_ir_held <= stall & (r_ir_held | imem_ack);
      end
      if (w_ld_pc) begin
        r_pc <= w_pc_next;
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_ir;
  assign opcode    = r_ir[31:26];
  assign funct     = r_ir[5:0];

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed per-instruction vectors with hand-computed
// resulting PCs, a cycle-by-cycle behavioural model compared every cycle,
// and literal checks around reset.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        Beq = 1'b0;
  logic        Bne = 1'b0;
  logic        J = 1'b0;
  logic        Z = 1'b0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  fetch_seq dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
    .Beq(Beq), .Bne(Bne), .J(J), .Z(Z), .jr(jr), .jr_target(jr_target),
    .stall(stall), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase counts the cycle position within one instruction (0 = waiting for
  // the word, 1 = decoder strobe, 2 = wait, 3 = PC update).
  bit          m_init = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ir = 32'h0;
  int          m_phase = 0;
  bit          m_got = 1'b0;
  int          rel_cnt = 0;
  bit          first_pending = 1'b0;

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ir,
                                              input logic c_jr, input logic c_j,
                                              input logic c_beq, input logic c_bne,
                                              input logic c_z, input logic [31:0] tgt);
    logic [31:0] seq;
    int          imm;
    seq = p + 32'd4;
    imm = int'($signed(ir[15:0]));
    if (c_jr) return tgt;
    if (c_j) return (seq & 32'hF000_0000) | ({6'b0, ir[25:0]} * 32'd4);
    if ((c_beq && c_z) || (c_bne && !c_z)) return seq + 32'(imm * 4);
    return seq;
  endfunction

  // Compare process: 8 time units after each rising edge (inputs for the next
  // edge are already driven), check outputs against the model, then advance it.
  always begin
    @(posedge clk);
    #8;
    if (!rst) begin
      chk1("req_during_reset", imem_req, 1'b0);
      chk1("valid_during_reset", instr_valid, 1'b0);
      m_init        = 1'b1;
      m_pc          = 32'h0;
      m_ir          = 32'h0;
      m_phase       = 0;
      m_got         = 1'b0;
      rel_cnt       = 0;
      first_pending = 1'b1;
    end else if (m_init) begin
      rel_cnt++;
      chk1("imem_req", imem_req, m_phase == 0);
      if (m_phase == 0) chk("imem_addr", imem_addr, m_pc);
      chk1("instr_valid", instr_valid, (m_phase == 1) && !stall);
      chk("pc", pc, m_pc);
      chk("instr", instr, m_ir);
      chk("opcode", {26'b0, opcode}, {26'b0, m_ir[31:26]});
      chk("funct", {26'b0, funct}, {26'b0, m_ir[5:0]});
      if (instr_valid && first_pending) begin
        first_pending = 1'b0;
        chk("first_valid_cycle", rel_cnt, 32'd2);
      end
      if (m_phase == 0) begin
        if (imem_ack) m_ir = imem_rdata;
        if (!stall && (imem_ack || m_got)) begin
          m_phase = 1;
          m_got   = 1'b0;
        end else if (stall && imem_ack) begin
          m_got = 1'b1;
        end
      end else if (!stall) begin
        if (m_phase == 3) begin
          m_pc    = model_next(m_pc, m_ir, jr, J, Beq, Bne, Z, jr_target);
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  localparam logic [4:0] C_JR  = 5'b10000;
  localparam logic [4:0] C_J   = 5'b01000;
  localparam logic [4:0] C_BEQ = 5'b00100;
  localparam logic [4:0] C_BNE = 5'b00010;
  localparam logic [4:0] C_Z   = 5'b00001;

  typedef struct {
    logic [31:0] word;
    int          dly;
    int          st_ph;
    int          st_len;
    logic [4:0]  ctrl;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] word, input int dly, input int st_ph,
                              input int st_len, input logic [4:0] ctrl,
                              input logic [31:0] tgt, input logic [31:0] exp_pc);
    vec_t v;
    v.word = word; v.dly = dly; v.st_ph = st_ph; v.st_len = st_len;
    v.ctrl = ctrl; v.tgt = tgt; v.exp_pc = exp_pc;
    return v;
  endfunction

  // Run one instruction: memory acks once after v.dly request cycles, controls
  // carry the vector only in the update cycle (noise elsewhere), optional stall.
  task automatic run_instr(input vec_t v, input int idx);
    int waited  = 0;
    int stalled = 0;
    int guard   = 0;
    int ph;
    bit done    = 1'b0;
    while (!done && guard < 60) begin
      @(negedge clk);
      guard++;
      ph    = m_phase;
      rst   = 1'b1;
      stall = (ph == v.st_ph) && (stalled < v.st_len);
      if (stall) stalled++;
      if (ph == 3) begin
        {jr, J, Beq, Bne, Z} = v.ctrl;
        jr_target = v.tgt;
      end else begin
        {jr, J, Beq, Bne} = 4'b1111;
        Z = (guard % 2) == 1;
        jr_target = 32'h5555_5554;
      end
      #1;
      if (imem_req) begin
        imem_ack   = (waited == v.dly);
        imem_rdata = imem_ack ? v.word : 32'hDEAD_BEEF;
        waited++;
      end else begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
      end
      if (ph == 3 && !stall) done = 1'b1;
    end
    @(posedge clk);
    #2;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL instr_timeout: instr %0d did not complete within 60 cycles", idx);
    end
    chk("pc_after", pc, v.exp_pc);
    chk1("req_after", imem_req, 1'b1);
    chk("addr_after", imem_addr, v.exp_pc);
    $display("instr %0d: word=%08h ctrl=%05b pc=%08h expected=%08h", idx, v.word, v.ctrl, pc, v.exp_pc);
  endtask

  // Hold reset for n cycles with every other input hostile (stall, controls, ack).
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; stall = 1'b1;
      {jr, J, Beq, Bne, Z} = 5'b11111;
      jr_target = 32'hFFFF_0000;
      #1;
      imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      #1;
      chk1("rst_req_low", imem_req, 1'b0);
      chk1("rst_valid_low", instr_valid, 1'b0);
    end
    @(posedge clk);
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    $display("reset: pc=%08h instr=%08h", pc, instr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(32'h2001_0005, 0, -1, 0, 5'b0,          32'h0,         32'h0000_0004));
    vecs.push_back(mk(32'h0800_0040, 0, -1, 0, C_J,           32'h0,         32'h0000_0100));
    vecs.push_back(mk(32'h1000_FFFE, 0, -1, 0, C_BEQ | C_Z,   32'h0,         32'h0000_00FC));
    vecs.push_back(mk(32'h0800_0040, 0, -1, 0, C_J,           32'h0,         32'h0000_0100));
    vecs.push_back(mk(32'h1000_FFFE, 0, -1, 0, C_BEQ,         32'h0,         32'h0000_0104));
    vecs.push_back(mk(32'h0800_0040, 0, -1, 0, C_J,           32'h0,         32'h0000_0100));
    vecs.push_back(mk(32'h1400_0003, 0, -1, 0, C_BNE,         32'h0,         32'h0000_0110));
    vecs.push_back(mk(32'h1400_0003, 0, -1, 0, C_BNE | C_Z,   32'h0,         32'h0000_0114));
    vecs.push_back(mk(32'h0800_0040, 0, -1, 0, C_JR | C_J,    32'h0000_0ABC, 32'h0000_0ABC));
    vecs.push_back(mk(32'h1000_0001, 0, -1, 0, C_BEQ | C_BNE | C_Z, 32'h0,   32'h0000_0AC4));
    vecs.push_back(mk(32'h1000_0001, 0, -1, 0, C_BEQ | C_BNE, 32'h0,         32'h0000_0ACC));
    vecs.push_back(mk(32'h0000_0008, 0, -1, 0, C_JR,          32'h0000_0123, 32'h0000_0123));
    vecs.push_back(mk(32'h0000_0008, 0, -1, 0, C_JR,          32'hFFFF_FFFC, 32'hFFFF_FFFC));
    vecs.push_back(mk(32'h0000_0020, 3, -1, 0, 5'b0,          32'h0,         32'h0000_0000));
    vecs.push_back(mk(32'h0022_1820, 0,  2, 5, 5'b0,          32'h0,         32'h0000_0004));
    vecs.push_back(mk(32'h8C01_0004, 1,  0, 4, 5'b0,          32'h0,         32'h0000_0008));
    vecs.push_back(mk(32'h0000_0025, 0,  1, 3, 5'b0,          32'h0,         32'h0000_000C));
    vecs.push_back(mk(32'h1000_0002, 0,  3, 2, C_BEQ | C_Z,   32'h0,         32'h0000_0018));
    vecs.push_back(mk(32'hFC00_FFFF, 0, -1, 0, 5'b0,          32'h0,         32'h0000_001C));
    vecs.push_back(mk(32'h0000_0008, 0, -1, 0, C_JR,          32'hFFFF_FFF8, 32'hFFFF_FFF8));
    vecs.push_back(mk(32'h1000_0001, 0, -1, 0, C_BEQ | C_Z,   32'h0,         32'h0000_0000));
    vecs.push_back(mk(32'h0000_0008, 0, -1, 0, C_JR,          32'h7FFF_FFF0, 32'h7FFF_FFF0));
    vecs.push_back(mk(32'h0800_0040, 0, -1, 0, C_J,           32'h0,         32'h7000_0100));

    do_reset(2);
    foreach (vecs[i]) run_instr(vecs[i], i);

    // Reset while a FETCH request is outstanding (no ack yet), with ack arriving
    // during the reset cycle; the request must drop and pc return to zero.
    @(negedge clk);
    rst = 1'b1; stall = 1'b0;
    {jr, J, Beq, Bne, Z} = 5'b0;
    #1;
    imem_ack = 1'b0;
    #1;
    chk1("midfetch_req_before", imem_req, 1'b1);
    do_reset(1);
    run_instr(mk(32'h2001_0005, 0, -1, 0, 5'b0, 32'h0, 32'h0000_0004), 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
